vr_crc_engine: RTL and testbench
================================

Name: vr_crc_engine

Overview:
Valid/ready CRC-32 stage. It consumes a stream of DATA-bit words on a vr-style slave port and accumulates a CRC over fixed-length frames of FRAME_WORDS words. At each frame end it emits the CRC as one word on a vr-style master port. It sits directly downstream of the vr stimulus/driver stream and feeds the result checker/scoreboard stream.

Parameters:
DATA, 32, stream data width; CRC folding requires DATA == 32.
FRAME_WORDS, 4, input words per frame; legal range 1..65535.
POLY, 32'h04C11DB7, CRC generator polynomial, normal (non-reflected) form.
INIT, 32'hFFFFFFFF, CRC register value at the start of every frame.
XOROUT, 32'h00000000, value XORed onto the final CRC before output.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  engine accepts the upstream word.
in_data  input  DATA  upstream word.
out_valid  output  1  CRC result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  32  CRC result.
frames_done  output  16  count of CRC results accepted downstream; wraps.

Behaviour:
- Single clock domain (clk). reset_n is asynchronous and active-low.
- Reset values: state=ACCUM, crc=INIT, word_cnt=0, in_ready=0, out_valid=0, out_data=0, frames_done=0.
- Input handshake: a word transfers on a rising edge where in_valid && in_ready.
- Output handshake: the result transfers on a rising edge where out_valid && out_ready.
- Registered outputs only. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- FSM with two states:
  - ACCUM: in_ready=1 from the first edge after reset release.
  - ACCUM, on each input transfer: crc <= fold(crc, in_data); word_cnt increments.
  - ACCUM, on the transfer with word_cnt == FRAME_WORDS-1: out_data <= fold(crc, in_data) ^ XOROUT; out_valid <= 1; in_ready <= 0; word_cnt <= 0; crc <= INIT; go to OUTPUT.
  - OUTPUT: in_ready=0, out_valid=1, and out_data held stable until the output transfer.
  - OUTPUT, on the output transfer: out_valid <= 0; in_ready <= 1; frames_done increments (modulo 2^16); go to ACCUM.
- fold(c, d): MSB-first bit-serial CRC fully unrolled in one cycle. For b = DATA-1 down to 0: fb = c[31] ^ d[b]; c = {c[30:0],1'b0} ^ (fb ? POLY : 0). Equivalent to (c ^ d)·x^32 mod P.
- Latency:
  - Last input transfer at edge N gives out_valid=1 after edge N.
  - With out_ready held high, the output transfer occurs at edge N+1 and in_ready=1 after edge N+1.
  - Throughput is therefore FRAME_WORDS+1 cycles per frame minimum.
- Upstream stalls (in_valid=0) and downstream backpressure (out_ready=0) may last any number of cycles with no state loss.
- Stability rules:
  - out_data must not change while out_valid=1 and out_ready=0.
  - out_valid must not drop without a transfer.
- in_data and in_valid are ignored while in_ready=0.
- FRAME_WORDS=1: every accepted word produces a result.
- frames_done wraps from 16'hFFFF to 16'h0000.
- reset_n asserted mid-frame or during OUTPUT:
  - All state returns to reset values immediately.
  - The partial CRC and any pending result are discarded; no output transfer occurs.
  - The next frame starts from INIT.
- Assertion (bench): $rose(out_valid) |-> out_valid throughout until (out_valid && out_ready); out_data $stable over the same window.

Test Plan:
1. INIT=0, FRAME_WORDS=1, in_data=32'h00000001, out_ready=1 -> out_data=32'h04C11DB7 one cycle after the input transfer; frames_done=1.
2. INIT=0, FRAME_WORDS=2, words {32'h00000000, 32'h00000001} -> out_data=32'h04C11DB7; in_ready=0 for exactly one cycle.
3. INIT=32'hFFFFFFFF, FRAME_WORDS=1, in_data=32'hFFFFFFFF -> out_data=0. With XOROUT=32'hFFFFFFFF -> out_data=32'hFFFFFFFF.
4. FRAME_WORDS=4, random words with in_valid gaps, out_ready held low 10 cycles -> out_valid and out_data stable all 10 cycles; in_ready=0 throughout; result matches the reference model; next frame accepted after the output transfer.
5. Assert reset_n after 2 of 4 words, release, send 4 words -> single result equal to the model over only the new 4 words; frames_done=1.
6. 65537 frames back-to-back with FRAME_WORDS=1 and out_ready=1 -> frames_done=1 (wrap); every result matches the model; no dropped or duplicated transfers.

Source files
------------

// File: rtl/vr_crc_engine.sv
// rtl/vr_crc_engine.sv - valid/ready CRC-32 engine emitting one CRC word per fixed-length frame
module vr_crc_engine #(
    parameter int          DATA        = 32,
    parameter int          FRAME_WORDS = 4,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT      = 32'h00000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [15:0]     frames_done
);

    typedef enum logic {ACCUM, OUTPUT} state_t;

    localparam logic [15:0] LAST_WORD = 16'(FRAME_WORDS - 1);

    state_t      state, state_next;
    logic [31:0] crc, crc_next, crc_fold;
    logic [15:0] word_cnt, word_cnt_next;
    logic        in_ready_next, out_valid_next;
    logic [31:0] out_data_next;
    logic [15:0] frames_next;

    // MSB-first bit-serial CRC, unrolled across the whole input word
    function automatic logic [31:0] fold(input logic [31:0] c, input logic [DATA-1:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int b = DATA - 1; b >= 0; b--) begin
            fb = r[31] ^ d[b];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ACCUM;
            crc         <= INIT;
            word_cnt    <= 16'd0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'h0;
            frames_done <= 16'd0;
        end else begin
            state       <= state_next;
            crc         <= crc_next;
            word_cnt    <= word_cnt_next;
            in_ready    <= in_ready_next;
            out_valid   <= out_valid_next;
            out_data    <= out_data_next;
            frames_done <= frames_next;
        end
    end

    always_comb begin
        state_next     = state;
        crc_next       = crc;
        word_cnt_next  = word_cnt;
        in_ready_next  = in_ready;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        frames_next    = frames_done;
        crc_fold       = fold(crc, in_data);
        case (state)
            ACCUM: begin
                in_ready_next = 1'b1;
                if (in_valid && in_ready) begin
                    if (word_cnt == LAST_WORD) begin
                        out_data_next  = crc_fold ^ XOROUT;
                        out_valid_next = 1'b1;
                        in_ready_next  = 1'b0;
                        word_cnt_next  = 16'd0;
                        crc_next       = INIT;
                        state_next     = OUTPUT;
                    end else begin
                        crc_next      = crc_fold;
                        word_cnt_next = word_cnt + 16'd1;
                    end
                end
            end
            OUTPUT: begin
                // result and in_ready=0 are held until the downstream takes it
                if (out_valid && out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    frames_next    = frames_done + 16'd1;
                    state_next     = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

endmodule

// File: tb/tb_vr_crc_engine.sv
// tb/tb_vr_crc_engine.sv - directed self-checking bench for vr_crc_engine over several parameter sets
module tb_vr_crc_engine;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    // instance: 0 INIT=0/FW=1, 1 INIT=0/FW=2, 2 default/FW=1, 3 XOROUT=F/FW=1, 4 default/FW=4
    localparam logic [79:0]  FW_V   = {16'd4, 16'd1, 16'd1, 16'd2, 16'd1};
    localparam logic [159:0] INIT_V = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    localparam logic [159:0] XOR_V  = {32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  in_valid = '0;
    logic [4:0]  in_ready;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready = '0;
    logic [31:0] in_data [5];
    logic [31:0] out_data [5];
    logic [15:0] frames_done [5];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        vr_crc_engine #(
            .DATA(32),
            .FRAME_WORDS(int'(FW_V[g*16 +: 16])),
            .POLY(POLY),
            .INIT(INIT_V[g*32 +: 32]),
            .XOROUT(XOR_V[g*32 +: 32])
        ) u_dut (
            .clk(clk),
            .reset_n(reset_n),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_data(in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data(out_data[g]),
            .frames_done(frames_done[g])
        );
    end

    // reference in the (c ^ d) * x^32 mod P form
    function automatic logic [31:0] fold_ref(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c ^ d;
        for (int k = 0; k < 32; k++)
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    function automatic logic [31:0] crc4(input logic [31:0] w0, w1, w2, w3);
        return fold_ref(fold_ref(fold_ref(fold_ref(32'hFFFFFFFF, w0), w1), w2), w3);
    endfunction

    // output stability while held off by backpressure
    logic [4:0]  prev_v = '0, prev_r = '0;
    logic        prev_rst = 1'b0;
    logic [31:0] prev_d [5];
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < 5; i++) begin
            if (reset_n && prev_rst && prev_v[i] && !prev_r[i]) begin
                compared++;
                if (out_valid[i] !== 1'b1 || out_data[i] !== prev_d[i]) begin
                    mismatched++;
                    $display("FAIL hold_stable[%0d]: valid=%b data=%h required valid=1 data=%h",
                             i, out_valid[i], out_data[i], prev_d[i]);
                end
            end
            prev_v[i] = out_valid[i];
            prev_r[i] = out_ready[i];
            prev_d[i] = out_data[i];
        end
        prev_rst = reset_n;
    end

    task automatic send_word(input int i, input logic [31:0] d, output bit ok);
        ok = 1'b0;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        for (int k = 0; k < 50; k++) begin
            if (in_ready[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid[i] = 1'b0;
    endtask

    task automatic get_result(input int i, output logic [31:0] d, output bit ok);
        ok = 1'b0;
        d  = 32'h0;
        out_ready[i] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (out_valid[i]) begin
                ok = 1'b1;
                d  = out_data[i];
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        out_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) in_data[i] = 32'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || out_data[i] !== 32'h0 || frames_done[i] !== 16'h0) begin
                mismatched++;
                $display("FAIL reset[%0d]: rdy=%b vld=%b data=%h frames=%h required all zero",
                         i, in_ready[i], out_valid[i], out_data[i], frames_done[i]);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        compared++;
        if (in_ready !== 5'b11111) begin
            mismatched++;
            $display("FAIL ready_after_reset: got %b required 11111", in_ready);
        end
    endtask

    task automatic test_single_word();
        bit ok;
        out_ready[0] = 1'b1;
        send_word(0, 32'h00000001, ok);
        compared++;
        if (!ok || out_valid[0] !== 1'b1 || out_data[0] !== 32'h04C11DB7) begin
            mismatched++;
            $display("FAIL fw1_init0: ok=%b vld=%b data=%h required 1/1/04c11db7", ok, out_valid[0], out_data[0]);
        end
        @(negedge clk);
        compared++;
        if (frames_done[0] !== 16'd1 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL fw1_accept: frames=%0d vld=%b rdy=%b required 1/0/1", frames_done[0], out_valid[0], in_ready[0]);
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_two_words();
        bit ok0, ok1;
        out_ready[1] = 1'b1;
        send_word(1, 32'h00000000, ok0);
        send_word(1, 32'h00000001, ok1);
        compared++;
        if (!ok0 || !ok1 || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || out_data[1] !== 32'h04C11DB7) begin
            mismatched++;
            $display("FAIL fw2_result: rdy=%b vld=%b data=%h required 0/1/04c11db7", in_ready[1], out_valid[1], out_data[1]);
        end
        @(negedge clk);
        compared++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || frames_done[1] !== 16'd1) begin
            mismatched++;
            $display("FAIL fw2_ready_gap: rdy=%b vld=%b frames=%0d required 1/0/1", in_ready[1], out_valid[1], frames_done[1]);
        end
        out_ready[1] = 1'b0;
    endtask

    task automatic test_xorout();
        bit ok;
        logic [31:0] d;
        send_word(2, 32'hFFFFFFFF, ok);
        get_result(2, d, ok);
        compared++;
        if (!ok || d !== 32'h00000000) begin
            mismatched++;
            $display("FAIL init_cancel: ok=%b data=%h required 00000000", ok, d);
        end
        send_word(3, 32'hFFFFFFFF, ok);
        get_result(3, d, ok);
        compared++;
        if (!ok || d !== 32'hFFFFFFFF) begin
            mismatched++;
            $display("FAIL xorout: ok=%b data=%h required ffffffff", ok, d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [4];
        logic [31:0] exp_crc, d;
        bit ok;
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        exp_crc = crc4(w[0], w[1], w[2], w[3]);
        for (int k = 0; k < 4; k++) begin
            send_word(4, w[k], ok);
            compared++;
            if (!ok) begin
                mismatched++;
                $display("FAIL bp_send[%0d]: ok=%b required 1", k, ok);
            end
            if (k < 3) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid[4] = 1'b1;
        in_data[4]  = 32'hDEADBEEF;
        for (int k = 0; k < 10; k++) begin
            compared++;
            if (out_valid[4] !== 1'b1 || out_data[4] !== exp_crc || in_ready[4] !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_hold[%0d]: vld=%b data=%h rdy=%b required 1/%h/0", k, out_valid[4], out_data[4], in_ready[4], exp_crc);
            end
            @(negedge clk);
        end
        in_valid[4] = 1'b0;
        get_result(4, d, ok);
        compared++;
        if (!ok || d !== exp_crc || frames_done[4] !== 16'd1) begin
            mismatched++;
            $display("FAIL bp_result: data=%h frames=%0d required %h/1", d, frames_done[4], exp_crc);
        end
        for (int k = 0; k < 4; k++) w[k] = 32'h11111111 * (k + 1);
        exp_crc = crc4(w[0], w[1], w[2], w[3]);
        for (int k = 0; k < 4; k++) send_word(4, w[k], ok);
        get_result(4, d, ok);
        compared++;
        if (!ok || d !== exp_crc || frames_done[4] !== 16'd2) begin
            mismatched++;
            $display("FAIL bp_next_frame: data=%h frames=%0d required %h/2", d, frames_done[4], exp_crc);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w [4];
        logic [31:0] exp_crc, d;
        bit ok;
        send_word(0, 32'h0000ABCD, ok);
        send_word(4, 32'hCAFEF00D, ok);
        send_word(4, 32'h12345678, ok);
        reset_n = 1'b0;
        @(negedge clk);
        compared++;
        if (out_valid[0] !== 1'b0 || in_ready[4] !== 1'b0 || frames_done[4] !== 16'd0) begin
            mismatched++;
            $display("FAIL midreset: vld0=%b rdy4=%b frames4=%0d required 0/0/0", out_valid[0], in_ready[4], frames_done[4]);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) w[k] = 32'hA5A50000 + 32'(k);
        exp_crc = crc4(w[0], w[1], w[2], w[3]);
        for (int k = 0; k < 4; k++) send_word(4, w[k], ok);
        get_result(4, d, ok);
        compared++;
        if (!ok || d !== exp_crc || frames_done[4] !== 16'd1) begin
            mismatched++;
            $display("FAIL post_reset_frame: data=%h frames=%0d required %h/1", d, frames_done[4], exp_crc);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 500;
        logic [31:0] expq [$];
        logic [31:0] d;
        int sent = 0, rcvd = 0, cyc = 0;
        bit ok;
        out_ready[2] = 1'b1;
        in_valid[2]  = 1'b1;
        while ((sent < N || rcvd < N) && cyc < 4000) begin
            if (sent >= N) in_valid[2] = 1'b0;
            if (out_valid[2]) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL b2b_extra: data=%h required no result", out_data[2]);
                end else begin
                    d = expq.pop_front();
                    if (out_data[2] !== d) begin
                        mismatched++;
                        $display("FAIL b2b_data[%0d]: got %h required %h", rcvd, out_data[2], d);
                    end
                end
                rcvd++;
            end
            if (in_ready[2] && sent < N) begin
                d = $urandom;
                in_data[2] = d;
                expq.push_back(fold_ref(32'hFFFFFFFF, d));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid[2] = 1'b0;
        compared++;
        if (rcvd != N || expq.size() != 0 || frames_done[2] !== 16'(N) || cyc > 2 * N + 4) begin
            mismatched++;
            $display("FAIL b2b_count: rcvd=%0d left=%0d frames=%0d cycles=%0d required %0d/0/%0d/<=%0d",
                     rcvd, expq.size(), frames_done[2], cyc, N, N, 2 * N + 4);
        end
        force g_dut[2].u_dut.frames_done = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release g_dut[2].u_dut.frames_done;
        @(negedge clk);
        send_word(2, 32'h00000000, ok);
        get_result(2, d, ok);
        compared++;
        if (!ok || d !== fold_ref(32'hFFFFFFFF, 32'h0) || frames_done[2] !== 16'h0000) begin
            mismatched++;
            $display("FAIL frames_wrap: data=%h frames=%h required %h/0000", d, frames_done[2], fold_ref(32'hFFFFFFFF, 32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_xorout();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
